// File: rtl/bp_pkg.sv
// Shared types, counter encodings and width helpers for the branch predictor.
package bp_pkg;

  localparam int BP_ADDR_W  = 32;
  localparam int BP_ENTRIES = 16;
  localparam int BP_CTR_W   = 2;

  // Two-bit counter encodings; wider counters use the generic midpoint values.
  localparam logic [1:0] CTR_SNT = 2'd0;
  localparam logic [1:0] CTR_WNT = 2'd1;
  localparam logic [1:0] CTR_WT  = 2'd2;
  localparam logic [1:0] CTR_ST  = 2'd3;

  function automatic int bp_clog2(input int value);
    int width;
    width = 0;
    while ((1 << width) < value) width++;
    return width;
  endfunction

  localparam int BP_IDX_W = bp_clog2(BP_ENTRIES);
  localparam int BP_TAG_W = BP_ADDR_W - BP_IDX_W - 2;

  typedef struct packed {
    logic                valid;
    logic [BP_TAG_W-1:0] tag;
    logic [BP_ADDR_W-1:0] target;
    logic [BP_CTR_W-1:0] ctr;
  } bp_entry_t;

endpackage

// File: rtl/branch_predictor_sat_counter.sv
// Combinational next-state of a CTR_W-bit saturating up/down counter.
module sat_counter #(
  parameter int CTR_W = 2
) (
  input  logic [CTR_W-1:0] cur,
  input  logic             inc,
  input  logic             dec,
  output logic [CTR_W-1:0] next
);

  always_comb begin
    next = cur;
    if (inc && (cur != {CTR_W{1'b1}})) begin
      next = cur + 1'b1;
    end else if (dec && (cur != '0)) begin
      next = cur - 1'b1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry saturating counters, looked up by IF, trained by ID.
// Optional statistics counters are built only when BP_STATS_EN is defined.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int ADDR_W  = BP_ADDR_W,
  parameter int ENTRIES = BP_ENTRIES,
  parameter int CTR_W   = BP_CTR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] lk_pc,
  output logic              lk_hit,
  output logic              lk_taken,
  output logic [ADDR_W-1:0] lk_target,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target,
  input  logic              upd_mispredict,
  input  logic              inv,
  input  logic              stat_clear,
  output logic [31:0]       stat_branches,
  output logic [31:0]       stat_mispredicts
);

  localparam int IDX_W = bp_clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;
  localparam logic [CTR_W-1:0] CTR_INIT  = CTR_W'((1 << (CTR_W - 1)) - 1);
  localparam logic [CTR_W-1:0] CTR_ALLOC = CTR_W'(1 << (CTR_W - 1));

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [ADDR_W-1:0] target;
    logic [CTR_W-1:0]  ctr;
  } entry_t;

  entry_t btb [ENTRIES];

  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic             upd_hit;
  logic [CTR_W-1:0] ctr_next;

  assign lk_idx  = lk_pc[IDX_W+1:2];
  assign lk_tag  = lk_pc[ADDR_W-1:IDX_W+2];
  assign upd_idx = upd_pc[IDX_W+1:2];
  assign upd_tag = upd_pc[ADDR_W-1:IDX_W+2];

  // Lookup reads registered state only, so a same-cycle write is not visible yet.
  always_comb begin
    lk_hit    = btb[lk_idx].valid && (btb[lk_idx].tag == lk_tag);
    lk_taken  = lk_hit && btb[lk_idx].ctr[CTR_W-1];
    lk_target = lk_hit ? btb[lk_idx].target : '0;
  end

  assign upd_hit = btb[upd_idx].valid && (btb[upd_idx].tag == upd_tag);

  sat_counter #(.CTR_W(CTR_W)) u_sat_counter (
    .cur  (btb[upd_idx].ctr),
    .inc  (upd_taken),
    .dec  (~upd_taken),
    .next (ctr_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        btb[i].valid  <= 1'b0;
        btb[i].tag    <= '0;
        btb[i].target <= '0;
        btb[i].ctr    <= CTR_INIT;
      end
    end else if (inv) begin
      for (int i = 0; i < ENTRIES; i++) begin
        btb[i].valid <= 1'b0;
      end
    end else if (upd_valid) begin
      if (upd_hit) begin
        btb[upd_idx].ctr <= ctr_next;
        if (upd_taken) btb[upd_idx].target <= upd_target;
      end else if (upd_taken) begin
        // Taken miss replaces whatever occupied this slot.
        btb[upd_idx].valid  <= 1'b1;
        btb[upd_idx].tag    <= upd_tag;
        btb[upd_idx].target <= upd_target;
        btb[upd_idx].ctr    <= CTR_ALLOC;
      end
    end
  end

`ifdef BP_STATS_EN
  logic [31:0] branches_q;
  logic [31:0] mispredicts_q;

  always_ff @(posedge clk) begin
    if (rst || stat_clear) begin
      branches_q    <= '0;
      mispredicts_q <= '0;
    end else if (upd_valid && !inv) begin
      if (branches_q != 32'hFFFF_FFFF) branches_q <= branches_q + 32'd1;
      if (upd_mispredict && (mispredicts_q != 32'hFFFF_FFFF)) begin
        mispredicts_q <= mispredicts_q + 32'd1;
      end
    end
  end

  assign stat_branches    = branches_q;
  assign stat_mispredicts = mispredicts_q;

  logic unused_bits;
  assign unused_bits = &{1'b0, lk_pc[1:0], upd_pc[1:0]};
`else
  assign stat_branches    = '0;
  assign stat_mispredicts = '0;

  logic unused_bits;
  assign unused_bits = &{1'b0, lk_pc[1:0], upd_pc[1:0], stat_clear, upd_mispredict};
`endif

endmodule
